// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - received-word handshake and status bundle for serial_rx
interface serial_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - asynchronous-serial receiver with one-entry holding register
module serial_rx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_in,
    serial_rx_if.master  rx_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    logic                 sync1_q, sync1_d;
    logic                 rxs_q, rxs_d;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 word_done;

    always_comb begin
        sync1_d   = rx_in;
        rxs_d     = sync1_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = ovr_q;
        word_done = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = rxs_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    // Right-shift in at the MSB so the first bit lands in bit 0.
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        word_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A consumer handshake on the completion edge frees the slot for the new word.
        if (word_done) begin
            if (!valid_q || rx_if.data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_if.data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            rxs_q     <= rxs_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_if.data_out   = data_q;
    assign rx_if.data_valid = valid_q;
    assign rx_if.frame_err  = ferr_q;
    assign rx_if.overrun    = ovr_q;
endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Asynchronous-serial receiver: the receiving end of the single-bit D-line stimulus streams our benches drive into the flip-flop blocks.
- Samples a 1-bit line framed as start bit (0), DATA_BITS data bits LSB first, stop bit (1), one bit every CLKS_PER_BIT clocks.
- Presents each byte through a one-entry valid/ready holding register.
- Reports framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame; range 5 to 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  DATA_BITS  received word.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts the word when data_valid && data_ready at a rising edge.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a completed word was dropped because the holding register was full.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values while rst_n is low:
  - Both synchroniser flops = 1.
  - State = IDLE; bit counter and cycle counter = 0; shift register = 0.
  - data_out = 0; data_valid = 0; frame_err = 0; overrun = 0.
  - A reset mid-frame abandons the frame with no output.
- Synchroniser: rx_in passes through 2 flops. All decisions use the synchronised value rxs, giving 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK. The cycle counter cnt clears on every state change and after every sample.
  - IDLE: rxs == 0 at edge E0 -> START.
  - START: sample when cnt == CLKS_PER_BIT/2 - 1.
    - rxs == 0 -> DATA.
    - rxs == 1 -> false start; return to IDLE with no flags.
  - DATA: sample when cnt == CLKS_PER_BIT - 1. Shift rxs in LSB-first (first data bit ends in bit 0). After DATA_BITS samples -> STOP.
  - STOP: sample when cnt == CLKS_PER_BIT - 1.
    - rxs == 1: word complete; go to IDLE.
    - rxs == 0: frame_err pulses high for exactly 1 cycle; word discarded; go to BREAK.
  - BREAK: wait for rxs == 1, then go to IDLE. This prevents a held-low line from retriggering.
- Timing: the stop-bit sample edge is E0 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT. That is E0 + 95 at the defaults.
- Holding register, on word completion at edge Ec:
  - data_valid == 0: load data_out; data_valid = 1 from Ec.
  - data_valid == 1 and data_ready == 1 at Ec: accept old word, load new word; data_valid stays 1; no overrun.
  - data_valid == 1 and data_ready == 0 at Ec: drop new word; data_out unchanged; overrun set.
- Accept with no completion: data_valid clears on the next edge. data_out holds its last value.
- overrun clears only on reset.
- data_ready while data_valid == 0 has no effect.
- Back-to-back frames are supported: a start edge seen in IDLE immediately after STOP is accepted.

Test Plan:
- Reset: hold rst_n low, rx_in = 1, then release -> all outputs 0; no activity with the line idle for 200 cycles.
- Single byte 0xA5 at CLKS_PER_BIT = 10, data_ready = 0 -> data_out = 0xA5; data_valid rises exactly 95 edges after E0 and holds; assert data_ready for 1 cycle -> data_valid = 0 the next edge.
- False start: rx_in low for 3 cycles, then high -> state returns to IDLE; no data_valid, no frame_err.
  - Follow with 0x3C -> 0x3C received correctly.
- Framing error: send 0x81 with the stop bit held low for 2 bit-times, then high -> frame_err pulses 1 cycle; data_valid stays 0; next frame 0x55 -> received as 0x55.
- Overrun: send 0x11 then 0x22 back to back, data_ready = 0 -> data_out = 0x11 and overrun = 1.
  - Repeat with data_ready = 1 exactly at the 0x22 completion edge -> data_out = 0x22, data_valid = 1, overrun = 0.
- Reset mid-frame: assert rst_n low during data bit 4 of 0xF0, release, then send 0x0F -> only 0x0F appears; no frame_err.
